// File: rtl/bip_control.sv
// rtl/bip_control.sv - fetch/execute control unit for the BIP accumulator machine
// Sequences IDLE/FETCH/EXEC/HALT and decodes the 5-bit opcode into datapath strobes.
module bip_control #(
  parameter logic [10:0] RESET_PC = 11'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [10:0] prog_addr,
  input  logic [15:0] prog_data,
  output logic [10:0] operand,
  output logic [1:0]  sel_a,
  output logic        sel_b,
  output logic        op,
  output logic        wr_acc,
  output logic        wr_ram,
  output logic        rd_ram,
  output logic        halted,
  output logic        bad_op,
  output logic [15:0] instr_count
);

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t     state;
  logic [4:0] opcode;
  logic       in_exec;
  logic       is_hlt;
  logic       is_undef;

  assign opcode   = prog_data[15:11];
  assign in_exec  = (state == EXEC);
  assign is_hlt   = (opcode == OP_HLT);
  assign is_undef = (opcode[4:3] != 2'b00);

  // Strobes follow the instruction word directly so they land in the EXEC cycle itself.
  always_comb begin
    operand = 11'd0;
    sel_a   = 2'b00;
    sel_b   = 1'b0;
    op      = 1'b0;
    wr_acc  = 1'b0;
    wr_ram  = 1'b0;
    rd_ram  = 1'b0;
    if (in_exec) begin
      operand = prog_data[10:0];
      case (opcode)
        OP_STO: wr_ram = 1'b1;
        OP_LD: begin
          sel_a  = 2'b00;
          wr_acc = 1'b1;
          rd_ram = 1'b1;
        end
        OP_LDI: begin
          sel_a  = 2'b01;
          wr_acc = 1'b1;
        end
        OP_ADD: begin
          sel_a  = 2'b10;
          wr_acc = 1'b1;
          rd_ram = 1'b1;
        end
        OP_ADDI: begin
          sel_a  = 2'b10;
          sel_b  = 1'b1;
          wr_acc = 1'b1;
        end
        OP_SUB: begin
          sel_a  = 2'b10;
          op     = 1'b1;
          wr_acc = 1'b1;
          rd_ram = 1'b1;
        end
        OP_SUBI: begin
          sel_a  = 2'b10;
          sel_b  = 1'b1;
          op     = 1'b1;
          wr_acc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prog_addr   <= RESET_PC;
      instr_count <= 16'd0;
      bad_op      <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end
        FETCH: state <= EXEC;
        EXEC: begin
          if (is_hlt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state     <= FETCH;
            prog_addr <= prog_addr + 11'd1;
            if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
            if (is_undef) bad_op <= 1'b1;
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bip_control.md
BIP_CONTROL -- requirements
Module: bip_control

Interface
REQ-001 Parameter: RESET_PC, 11'd0, program counter value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; one clock, asynchronous active-high reset.
REQ-004 start  input  1  level/pulse; leaves IDLE when sampled high.
REQ-005 prog_addr  output  11  program counter, drives program-memory address.
REQ-006 prog_data  input  16  instruction from synchronous program memory, valid one cycle after prog_addr; opcode [15:11], operand [10:0].
REQ-007 operand  output  11  to sign-extension block; prog_data[10:0] in EXEC, 11'd0 otherwise.
REQ-008 sel_a  output  2  accumulator source: 00 data memory, 01 sign-extended operand, 10 ALU result.
REQ-009 sel_b  output  1  ALU B source: 0 data memory, 1 sign-extended operand.
REQ-010 op  output  1  ALU operation: 0 add, 1 sub.
REQ-011 wr_acc  output  1  accumulator write strobe.
REQ-012 wr_ram  output  1  data-memory write strobe.
REQ-013 rd_ram  output  1  data-memory read enable; data memory reads asynchronously.
REQ-014 halted  output  1  high while in HALT.
REQ-015 bad_op  output  1  sticky flag: undefined opcode executed.
REQ-016 instr_count  output  16  instructions retired, HLT excluded.

Function
REQ-017 States: IDLE, FETCH, EXEC, HALT; registered state, 2-bit encoding.
REQ-018 IDLE: start=1 -> FETCH; otherwise remain; start ignored in all other states.
REQ-019 FETCH: prog_addr presented; unconditional -> EXEC next cycle.
REQ-020 EXEC: decode prog_data[15:11]; strobes combinational from it, asserted only in EXEC, all zero in other states.
REQ-021 Decode table (unlisted outputs 0): HLT 00000 -> none; STO 00001 -> wr_ram; LD 00010 -> sel_a=00, wr_acc, rd_ram; LDI 00011 -> sel_a=01, wr_acc; ADD 00100 -> sel_a=10, sel_b=0, op=0, wr_acc, rd_ram; ADDI 00101 -> sel_a=10, sel_b=1, op=0, wr_acc; SUB 00110 -> sel_a=10, sel_b=0, op=1, wr_acc, rd_ram; SUBI 00111 -> sel_a=10, sel_b=1, op=1, wr_acc.
REQ-022 EXEC non-HLT: PC <= PC+1 (11-bit, 2047 wraps to 0), instr_count +1, -> FETCH.
REQ-023 EXEC HLT: PC unchanged, instr_count unchanged, -> HALT.
REQ-024 Opcodes 01000-11111: behave as NOP (no strobes), set bad_op, PC/instr_count advance, -> FETCH.
REQ-025 HALT: absorbing until reset; halted=1; PC frozen; no strobes.
REQ-026 instr_count saturates at 16'hFFFF; no wrap.
REQ-027 Throughput: one instruction per 2 cycles; strobes for instruction at address N valid in cycle following the FETCH of N.

Reset
REQ-028 reset high: state=IDLE, prog_addr=RESET_PC, instr_count=0, bad_op=0, halted=0, all strobes 0, operand=0, immediately and independent of clk.
REQ-029 Reset asserted mid-EXEC: strobes drop asynchronously; no PC increment; restart requires start.

Verification
REQ-030 Reset, start pulse, prog: 0:LDI 5, 1:ADDI 3, 2:HLT -> EXEC cycles show (sel_a=01,wr_acc), (sel_a=10,sel_b=1,op=0,wr_acc), then halted=1, prog_addr=2, instr_count=2.
REQ-031 STO 7 then LD 7 then SUB 7 -> wr_ram=1 with operand=7; rd_ram=1,sel_a=00; rd_ram=1,op=1,sel_b=0; each strobe exactly 1 cycle.
REQ-032 Opcode 01010 at address 4 -> no strobes, bad_op=1 and stays 1, prog_addr=5 afterward.
REQ-033 RESET_PC=11'd2047, instruction LDI 1 -> prog_addr 2047 -> 0 after EXEC.
REQ-034 Assert reset during EXEC of ADD -> wr_acc falls before next clk edge; state IDLE, prog_addr=RESET_PC; start held low -> stays IDLE.
REQ-035 Force instr_count to 16'hFFFE, run 3 NOPs (LDI) -> count reads FFFF, FFFF, FFFF.
